decoder_seq_sweep: RTL
======================

// Module: decoder_seq_sweep
// PURPOSE
//   Parametrised N-to-2^N one-hot decoder with a registered output and a built-in sweep sequencer.
//   Normal mode: drives the register-file write-enable lines from a decoded select, one cycle after `en`.
//   Sweep mode: walks a single active line across every output, one line per cycle.
//   Sweep is used to clear the register file after reset, and sits between the control unit and the register file.
// PARAMETERS
//   SEL_W        5   select width; legal range 1..8; OUT_W = 2**SEL_W (localparam, not overridable)
//   SWEEP_SKIP0  1   1: sweep starts at index 1 (index 0 is the hardwired zero reg); 0: sweep starts at index 0
// PORTS
//   clk          in   1      clock; all state updates on the rising edge
//   rst_n        in   1      reset; asynchronous, active-low
//   en           in   1      decode request; honoured only in IDLE
//   sel          in   SEL_W  index to decode when en=1
//   sweep_start  in   1      start a sweep; honoured only in IDLE; wins over en
//   stall        in   1      freeze the sweep: state, idx and out all hold; ignored outside SWEEP
//   out          out  OUT_W  registered one-hot (or all-zero) enable vector
//   busy         out  1      high in SWEEP and DONE
//   done         out  1      one-cycle pulse in DONE
//   cur_idx      out  SEL_W  current sweep index; 0 when IDLE
// BEHAVIOUR
//   Reset (rst_n=0, async)
//     - state=IDLE, idx=0, out=0, busy=0, done=0, cur_idx=0.
//     - Reset asserted mid-sweep aborts the sweep immediately; no done pulse is produced.
//   States: IDLE, SWEEP, DONE. FIRST = SWEEP_SKIP0 ? 1 : 0.
//   IDLE, at each edge:
//     - sweep_start=1: state<=SWEEP, idx<=FIRST, out<=1<<FIRST, busy<=1; en is ignored this edge.
//     - else en=1: out<=1<<sel (latency 1 cycle).
//     - else: out<=0.
//   SWEEP, at each edge:
//     - stall=1: hold everything.
//     - else idx==OUT_W-1: state<=DONE, out<=0, done<=1.
//     - else: idx<=idx+1, out<=1<<(idx+1).
//     - en, sel and sweep_start are ignored (dropped, not queued).
//   DONE, at the next edge: state<=IDLE, done<=0, busy<=0, idx<=0, out<=0.
//     - A sweep_start present during DONE is ignored; a new sweep needs sweep_start in IDLE.
//   Invariants
//     - popcount(out) <= 1 at all times.
//     - Each swept index is high for >=1 cycle, in ascending order; no wrap past OUT_W-1.
//   Timing
//     - Unstalled sweep: out active for OUT_W-FIRST cycles, then 1 DONE cycle.
//     - Back-to-back en in IDLE: out tracks sel with 1-cycle latency.
//     - sel=OUT_W-1 decodes to the MSB (no overflow).
// TESTING
//   1. Reset, SEL_W=5: en=1, sel=0,7,31 on consecutive cycles -> out=0x00000001, 0x00000080, 0x80000000 one cycle later each; en=0 -> out=0.
//   2. SEL_W=5, SKIP0=1: sweep_start at cycle 0 -> out=0x00000002 at cycle 1 ... 0x80000000 at cycle 31; done=1 and out=0 at cycle 32; busy=0 at cycle 33.
//   3. Sweep with stall=1 for cycles 5..7 -> out/cur_idx frozen at idx 5 for 3 extra cycles; done arrives at cycle 35.
//   4. sweep_start and en both high in IDLE -> sweep begins; en ignored; en/sweep_start pulses during SWEEP have no effect.
//   5. rst_n=0 at cycle 10 of a sweep -> out=0, busy=0 asynchronously; no done pulse; a later sweep_start restarts from FIRST.
//   6. SEL_W=3, SKIP0=0 -> sweep drives 0x01..0x80 over 8 cycles; one-hot assertion checked every cycle.

Source files
------------

// File: rtl/decoder_seq_sweep.sv
// One-hot N-to-2^N decoder with a registered output and a built-in sweep sequencer
// that walks a single enable line across every output, e.g. to clear a register file.
module decoder_seq_sweep #(
  parameter int unsigned SEL_W       = 5,
  parameter bit          SWEEP_SKIP0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sweep_start,
  input  logic                  stall,
  output logic [(2**SEL_W)-1:0] out,
  output logic                  busy,
  output logic                  done,
  output logic [SEL_W-1:0]      cur_idx
);

  localparam int unsigned       OUT_W = 2 ** SEL_W;
  localparam logic [SEL_W-1:0]  FIRST = SEL_W'(SWEEP_SKIP0 ? 1 : 0);
  localparam logic [SEL_W-1:0]  LAST  = SEL_W'(OUT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q,   idx_d;
  logic [OUT_W-1:0]   out_q,   out_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Next-state and next-output logic; every register holds unless told otherwise.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = done_q;

    unique case (state_q)
      S_IDLE: begin
        idx_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (sweep_start) begin
          state_d = S_SWEEP;
          idx_d   = FIRST;
          out_d   = onehot(FIRST);
          busy_d  = 1'b1;
        end else if (en) begin
          out_d = onehot(sel);
        end else begin
          out_d = '0;
        end
      end

      S_SWEEP: begin
        // Sweep requests and decode requests are dropped while sweeping.
        if (!stall) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
            out_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + SEL_W'(1);
            out_d = onehot(idx_q + SEL_W'(1));
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
        out_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        out_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cur_idx = idx_q;

endmodule
